// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: observer-side trace sink for the MIPS core.
// Captures one (pc, alu) pair per enabled clock into a DEPTH-entry FIFO.
// The FIFO is first-word-fall-through and drains over a valid/ready read port.
// Overflow handling: a capture that arrives while the FIFO is full and not popping
// is dropped. It sets the sticky overflow flag and bumps a saturating drop counter.
//
// Optional feature (macro TRACE_DEDUP_EN): a capture whose pc equals the last
// pushed pc is suppressed. It is neither stored nor counted as a drop.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous flush of FIFO, overflow flag and drop counter
//   cap_en          capture enable
//   pc_in, alu_in   sample inputs from the core
//   rd_valid        head entry available
//   rd_ready        reader accepts head entry
//   rd_pc, rd_alu   head entry (0 when empty)
//   count           entries stored, 0..DEPTH
//   overflow        sticky dropped-sample flag
//   drop_cnt        saturating dropped-sample counter
module mips_trace_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = 2,
    parameter int unsigned DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              cap_en,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       alu_in,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [31:0]       rd_pc,
    output logic [31:0]       rd_alu,
    output logic [PTR_W:0]    count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [31:0]      mem_pc  [DEPTH];
    logic [31:0]      mem_alu [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             cand;
    logic             push;
    logic             pop;
    logic             drop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

`ifdef TRACE_DEDUP_EN
    // Remember the most recently stored pc so repeats can be suppressed.
    logic [31:0] last_pc;
    logic        last_valid;

    assign cand = cap_en && !(last_valid && (pc_in == last_pc));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_valid <= 1'b0;
            last_pc    <= '0;
        end else if (clr) begin
            last_valid <= 1'b0;
        end else if (push) begin
            last_valid <= 1'b1;
            last_pc    <= pc_in;
        end
    end
`else
    assign cand = cap_en;
`endif

    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    assign pop  = !empty && rd_ready;
    assign push = cand && (!full || pop);
    assign drop = cand && full && !pop;

    // Head entry falls through combinationally; zeroed when nothing is stored.
    assign rd_valid = !empty;
    assign rd_pc    = empty ? 32'h0 : mem_pc[rd_ptr];
    assign rd_alu   = empty ? 32'h0 : mem_alu[rd_ptr];

    // Storage needs no reset; only entries behind valid pointers are observed.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_pc[wr_ptr]  <= pc_in;
            mem_alu[wr_ptr] <= alu_in;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Bench for mips_trace_buffer: a queue-based reference model is compared to the
// DUT on every falling edge, plus literal expectations for the directed scenarios.
module tb_mips_trace_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned DROP_W = 8;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              cap_en;
    logic [31:0]       pc_in;
    logic [31:0]       alu_in;
    logic              rd_valid;
    logic              rd_ready;
    logic [31:0]       rd_pc;
    logic [31:0]       rd_alu;
    logic [PTR_W:0]    count;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    int total = 0;
    int bad   = 0;
    logic checking = 1'b0;

    // Reference model state.
    logic [63:0] q[$];
    logic        m_ovf;
    int          m_drops;
    logic [31:0] m_last_pc;
    logic        m_last_v;

    mips_trace_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DROP_W(DROP_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .cap_en   (cap_en),
        .pc_in    (pc_in),
        .alu_in   (alu_in),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_pc    (rd_pc),
        .rd_alu   (rd_alu),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf     = 1'b0;
        m_drops   = 0;
        m_last_v  = 1'b0;
        m_last_pc = '0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_update();
        logic do_pop;
        logic was_full;
        logic take;
        if (clr) begin
            model_reset();
            return;
        end
        was_full = (q.size() == DEPTH);
        do_pop   = (q.size() != 0) && rd_ready;
        take     = cap_en;
`ifdef TRACE_DEDUP_EN
        if (m_last_v && pc_in == m_last_pc) take = 1'b0;
`endif
        if (do_pop) void'(q.pop_front());
        if (take) begin
            if (!was_full || do_pop) begin
                q.push_back({pc_in, alu_in});
                m_last_pc = pc_in;
                m_last_v  = 1'b1;
            end else begin
                m_ovf = 1'b1;
                if (m_drops < (1 << DROP_W) - 1) m_drops++;
            end
        end
    endtask

    task automatic check_model();
        logic [63:0] head;
        head = (q.size() != 0) ? q[0] : 64'h0;
        cmp("m_rd_valid", 32'(rd_valid), 32'(q.size() != 0));
        cmp("m_rd_pc",    rd_pc,  head[63:32]);
        cmp("m_rd_alu",   rd_alu, head[31:0]);
        cmp("m_count",    32'(count), 32'(q.size()));
        cmp("m_overflow", 32'(overflow), 32'(m_ovf));
        cmp("m_drop_cnt", 32'(drop_cnt), 32'(m_drops));
    endtask

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (checking && rst_n) check_model();
    end

    task automatic step(input logic c, input logic [31:0] pc, input logic [31:0] alu,
                        input logic rdy, input logic cl);
        cap_en   = c;
        pc_in    = pc;
        alu_in   = alu;
        rd_ready = rdy;
        clr      = cl;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic fill4();
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 32'(i + 1), 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; cap_en = 1'b0; rd_ready = 1'b0;
        pc_in = '0; alu_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        cmp("reset_rd_valid", 32'(rd_valid), 32'd0);
        cmp("reset_count",    32'(count),    32'd0);
        cmp("reset_overflow", 32'(overflow), 32'd0);
        cmp("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        cmp("reset_rd_pc",    rd_pc,         32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        checking = 1'b1;

        // Fill then drain in order.
        fill4();
        cmp("fill_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            cmp("drain_pc",  rd_pc,  32'(i * 4));
            cmp("drain_alu", rd_alu, 32'(i + 1));
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        cmp("drained_valid", 32'(rd_valid), 32'd0);

        // Empty with rd_ready held: nothing happens.
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cmp("empty_ready_count", 32'(count), 32'd0);

        // Overflow: three drops while full.
        fill4();
        for (int i = 0; i < 3; i++) step(1'b1, 32'h40 + 32'(i * 4), 32'h99, 1'b0, 1'b0);
        cmp("ovf_flag",  32'(overflow), 32'd1);
        cmp("ovf_drops", 32'(drop_cnt), 32'd3);
        cmp("ovf_count", 32'(count),    32'd4);
        cmp("ovf_head_pc",  rd_pc,  32'h0);
        cmp("ovf_head_alu", rd_alu, 32'h1);
        step(1'b1, 32'h80, 32'h5, 1'b1, 1'b1);
        cmp("clr_count",    32'(count),    32'd0);
        cmp("clr_overflow", 32'(overflow), 32'd0);
        cmp("clr_drop_cnt", 32'(drop_cnt), 32'd0);
        cmp("clr_valid",    32'(rd_valid), 32'd0);

        // Full plus simultaneous push/pop.
        fill4();
        step(1'b1, 32'h10, 32'h5, 1'b1, 1'b0);
        cmp("fpp_count", 32'(count),    32'd4);
        cmp("fpp_drops", 32'(drop_cnt), 32'd0);
        cmp("fpp_head",  rd_pc,         32'h4);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cmp("fpp_fourth_pc",  rd_pc,  32'h10);
        cmp("fpp_fourth_alu", rd_alu, 32'h5);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Pointer wrap with continuous push/pop.
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 32'h100 + 32'(k * 4), 32'(k + 10), 1'b1, 1'b0);
            cmp("wrap_head", rd_pc, 32'h100 + 32'(k * 4));
            cmp("wrap_count", 32'(count), 32'd1);
        end

        // Async reset between edges.
        #2 rst_n = 1'b0;
        #1;
        cmp("async_rd_valid", 32'(rd_valid), 32'd0);
        cmp("async_count",    32'(count),    32'd0);
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Drop counter saturation.
        fill4();
        for (int i = 0; i < 300; i++) step(1'b1, 32'h1000 + 32'(i * 4), 32'h7, 1'b0, 1'b0);
        cmp("sat_drop_cnt", 32'(drop_cnt), 32'hff);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Repeated pc captures.
        step(1'b1, 32'h20, 32'h1, 1'b0, 1'b0);
        step(1'b1, 32'h20, 32'h2, 1'b0, 1'b0);
        step(1'b1, 32'h24, 32'h3, 1'b0, 1'b0);
        step(1'b1, 32'h24, 32'h4, 1'b0, 1'b0);
`ifdef TRACE_DEDUP_EN
        cmp("dedup_count", 32'(count), 32'd2);
`else
        cmp("dedup_count", 32'(count), 32'd4);
`endif
        cmp("dedup_drops", 32'(drop_cnt), 32'd0);
        cmp("dedup_head",  rd_pc,         32'h20);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7),
                 32'($urandom_range(0, 5) * 4),
                 $urandom,
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 99) < 2));
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
